uart_cmd_parser: RTL and testbench

- Sits directly downstream of the 2 Mbps UART byte receiver in the SDRAM test design.
- Consumes the receiver's byte strobe and byte data, then assembles fixed-format command frames: opcode, 24-bit address, and optional 16-bit write data.
- Presents each complete command to the SDRAM test controller over a valid/ready handshake.
- Discards bad or stalled frames through an inter-byte timeout and reports them with error pulses.

---
 rtl/uart_cmd_pkg.sv | 17 +
 rtl/uart_byte_strobe.sv | 25 ++
 rtl/uart_cmd_parser.sv | 144 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command frame parser.
// Opcodes, state encoding, frame byte counts and timeout default.
package uart_cmd_pkg;

   localparam logic [7:0] OP_WRITE_DEF = 8'h57;
   localparam logic [7:0] OP_READ_DEF  = 8'h52;

   localparam int TIMEOUT_DEF = 50000;
   localparam int ADDR_BYTES  = 3;
   localparam int DATA_BYTES  = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ADDR  = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_ISSUE = 2'd3;

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's level-style done flag into one strobe per byte.
// The byte is passed through so it is sampled in the strobe cycle.
module uart_byte_strobe (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_done,
   input  logic [7:0] uart_data,
   output logic       byte_stb,
   output logic [7:0] byte_data
);

   logic done_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= uart_done;
      end
   end

   assign byte_stb  = uart_done & ~done_q;
   assign byte_data = uart_data;

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles opcode/address/data frames from UART bytes and
// presents them as commands over a valid/ready handshake.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter logic [7:0] OP_WRITE       = OP_WRITE_DEF,
   parameter logic [7:0] OP_READ        = OP_READ_DEF
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        uart_done,
   input  logic [7:0]  uart_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_wr,
   output logic [23:0] cmd_addr,
   output logic [15:0] cmd_wdata,
   output logic        err_opcode,
   output logic        err_timeout,
   output logic        err_overrun
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
   localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

   logic          byte_stb;
   logic [7:0]    byte_data;
   logic [1:0]    state;
   logic [1:0]    bcnt;
   logic [TW-1:0] tcnt;
   logic          in_frame;
   logic          expired;

   uart_byte_strobe u_strobe (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .uart_done (uart_done),
      .uart_data (uart_data),
      .byte_stb  (byte_stb),
      .byte_data (byte_data)
   );

   assign in_frame = (state == ST_ADDR) || (state == ST_DATA);
   assign expired  = in_frame && !byte_stb && (tcnt == T_LAST);

   // Inter-byte timer: only runs while a frame is partially received
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tcnt <= '0;
      end else if (byte_stb || !in_frame || expired) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= ST_IDLE;
         bcnt        <= 2'd0;
         cmd_valid   <= 1'b0;
         cmd_wr      <= 1'b0;
         cmd_addr    <= 24'd0;
         cmd_wdata   <= 16'd0;
         err_opcode  <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         err_opcode  <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         unique case (1'b1)
            state == ST_IDLE: begin
               if (byte_stb) begin
                  bcnt <= 2'd0;
                  if (byte_data == OP_WRITE) begin
                     cmd_wr <= 1'b1;
                     state  <= ST_ADDR;
                  end else if (byte_data == OP_READ) begin
                     cmd_wr <= 1'b0;
                     state  <= ST_ADDR;
                  end else begin
                     err_opcode <= 1'b1;
                  end
               end
            end
            state == ST_ADDR: begin
               if (byte_stb) begin
                  cmd_addr <= {cmd_addr[15:0], byte_data};
                  if (bcnt == ADDR_LAST) begin
                     bcnt <= 2'd0;
                     if (cmd_wr) begin
                        state <= ST_DATA;
                     end else begin
                        cmd_wdata <= 16'd0;
                        cmd_valid <= 1'b1;
                        state     <= ST_ISSUE;
                     end
                  end else begin
                     bcnt <= bcnt + 2'd1;
                  end
               end else if (expired) begin
                  err_timeout <= 1'b1;
                  bcnt        <= 2'd0;
                  state       <= ST_IDLE;
               end
            end
            state == ST_DATA: begin
               if (byte_stb) begin
                  cmd_wdata <= {cmd_wdata[7:0], byte_data};
                  if (bcnt == DATA_LAST) begin
                     bcnt      <= 2'd0;
                     cmd_valid <= 1'b1;
                     state     <= ST_ISSUE;
                  end else begin
                     bcnt <= bcnt + 2'd1;
                  end
               end else if (expired) begin
                  err_timeout <= 1'b1;
                  bcnt        <= 2'd0;
                  state       <= ST_IDLE;
               end
            end
            state == ST_ISSUE: begin
               // A byte arriving here is lost even on the handshake cycle
               if (byte_stb) begin
                  err_overrun <= 1'b1;
               end
               if (cmd_valid && cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized scoreboard bench for uart_cmd_parser.
// A frame-level model predicts commands and error pulses.
module tb_uart_cmd_parser;

   localparam int T = 40;

   typedef struct {
      logic        wr;
      logic [23:0] addr;
      logic [15:0] wdata;
   } cmd_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        uart_done = 1'b0;
   logic [7:0]  uart_data = 8'h00;
   logic        cmd_ready = 1'b0;
   logic        cmd_valid;
   logic        cmd_wr;
   logic [23:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic        err_opcode;
   logic        err_timeout;
   logic        err_overrun;

   int n_checks = 0;
   int n_fail = 0;

   cmd_t       cmd_q[$];
   int         err_q[$];
   logic [7:0] frame[$];
   bit         pending = 1'b0;

   always #10 sys_clk = ~sys_clk;

   uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .uart_done   (uart_done),
      .uart_data   (uart_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_wr      (cmd_wr),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .err_opcode  (err_opcode),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   function automatic void check(string name, logic [31:0] act,
                                 logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Frame-level model: 'W' + 3 addr + 2 data, or 'R' + 3 addr
   function automatic void model_byte(logic [7:0] b);
      cmd_t c;
      int   need;
      if (pending) begin
         err_q.push_back(3);
         return;
      end
      if (frame.size() == 0) begin
         if (b == 8'h57 || b == 8'h52) frame.push_back(b);
         else err_q.push_back(1);
         return;
      end
      frame.push_back(b);
      need = (frame[0] == 8'h57) ? 6 : 4;
      if (frame.size() == need) begin
         c.wr    = (frame[0] == 8'h57);
         c.addr  = {frame[1], frame[2], frame[3]};
         c.wdata = c.wr ? {frame[4], frame[5]} : 16'h0;
         cmd_q.push_back(c);
         frame.delete();
         pending = !cmd_ready;
      end
   endfunction

   function automatic void model_silence();
      if (frame.size() != 0) begin
         err_q.push_back(2);
         frame.delete();
      end
   endfunction

   function automatic void model_reset();
      frame.delete();
      if (pending) void'(cmd_q.pop_back());
      pending = 1'b0;
   endfunction

   // Strobe-to-strobe spacing is h+l; beyond T the frame times out
   task automatic send_byte(logic [7:0] b, int h, int l);
      model_byte(b);
      if (h + l > T) model_silence();
      uart_data = b;
      uart_done = 1'b1;
      repeat (h) @(posedge sys_clk);
      #1 uart_done = 1'b0;
      uart_data = 8'($urandom);
      repeat (l) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_short(logic [7:0] b);
      send_byte(b, 13, 3);
   endtask

   task automatic release_cmd();
      cmd_ready = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1 pending = 1'b0;
   endtask

   task automatic check_zero(string tag);
      check({tag, "_valid"}, 32'(cmd_valid), 32'h0);
      check({tag, "_wr"}, 32'(cmd_wr), 32'h0);
      check({tag, "_addr"}, 32'(cmd_addr), 32'h0);
      check({tag, "_wdata"}, 32'(cmd_wdata), 32'h0);
      check({tag, "_errs"},
            32'({err_opcode, err_timeout, err_overrun}), 32'h0);
   endtask

   // Monitor: compares every presented command and error pulse
   initial begin
      bit   prev_hs;
      bit   hs;
      int   kind;
      cmd_t c;
      prev_hs = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n) begin
            prev_hs = 1'b0;
            continue;
         end
         hs = cmd_valid && cmd_ready;
         if (prev_hs) check("valid_drop", 32'(cmd_valid), 32'h0);
         if (cmd_valid) begin
            if (cmd_q.size() == 0) begin
               check("cmd_unexpected", 32'h1, 32'h0);
            end else begin
               c = cmd_q[0];
               check("cmd_wr", 32'(cmd_wr), 32'(c.wr));
               check("cmd_addr", 32'(cmd_addr), 32'(c.addr));
               check("cmd_wdata", 32'(cmd_wdata), 32'(c.wdata));
               if (hs) void'(cmd_q.pop_front());
            end
         end
         if ({err_opcode, err_timeout, err_overrun} != 3'b000) begin
            check("err_onehot",
                  32'($countones({err_opcode, err_timeout, err_overrun})),
                  32'h1);
            kind = err_opcode ? 1 : (err_timeout ? 2 : 3);
            if (err_q.size() == 0) check("err_unexpected", 32'(kind), 32'h0);
            else check("err_kind", 32'(kind), 32'(err_q.pop_front()));
         end
         prev_hs = hs;
      end
   end

   initial begin
      int         h;
      int         l;
      int         r;
      int         k;
      logic [7:0] b;
      logic [7:0] op;

      repeat (3) @(posedge sys_clk);
      #1 check_zero("reset");
      sys_rst_n = 1'b1;
      cmd_ready = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;

      // Write frame with long done pulses
      send_short(8'h57); send_short(8'h12); send_short(8'h34);
      send_short(8'h56); send_short(8'hAB); send_short(8'hCD);
      repeat (5) @(posedge sys_clk);
      #1;

      // Read frame stalled by the consumer
      cmd_ready = 1'b0;
      send_short(8'h52); send_short(8'h00); send_short(8'h00);
      send_short(8'h10);
      repeat (100) @(posedge sys_clk);
      #1;
      check("stall_valid", 32'(cmd_valid), 32'h1);
      check("stall_wr", 32'(cmd_wr), 32'h0);
      check("stall_addr", 32'(cmd_addr), 32'h000010);
      check("stall_wdata", 32'(cmd_wdata), 32'h0);
      release_cmd();

      // Unknown opcode, then a good read
      send_short(8'h41);
      send_short(8'h52); send_short(8'h01); send_short(8'h02);
      send_short(8'h03);

      // Timeout after partial frame, then recovery
      send_short(8'h57);
      send_byte(8'h12, 13, T + 5);
      send_short(8'h52); send_short(8'h00); send_short(8'h00);
      send_short(8'h01);

      // Strobe spacing exactly T: byte wins over expiry
      send_byte(8'h52, 13, T - 13); send_byte(8'h0A, 13, T - 13);
      send_byte(8'h0B, 13, T - 13); send_byte(8'h0C, 13, 3);
      // Strobe spacing T+1: frame expires
      send_byte(8'h57, 13, T - 12);
      send_short(8'h52); send_short(8'h11); send_short(8'h22);
      send_short(8'h33);

      // Overrun while a command is pending
      cmd_ready = 1'b0;
      send_short(8'h52); send_short(8'h44); send_short(8'h55);
      send_short(8'h66);
      send_short(8'h57);
      repeat (5) @(posedge sys_clk);
      #1 check("ovr_addr", 32'(cmd_addr), 32'h445566);
      release_cmd();
      send_short(8'h52); send_short(8'h77); send_short(8'h88);
      send_short(8'h99);

      // Reset mid-frame
      send_short(8'h57); send_short(8'h12); send_short(8'h34);
      #3 sys_rst_n = 1'b0;
      model_reset();
      #1 check_zero("rst_frame");
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      send_short(8'h52); send_short(8'hAA); send_short(8'hBB);
      send_short(8'hCC);

      // Reset while a command is pending drops cmd_valid at once
      cmd_ready = 1'b0;
      send_short(8'h52); send_short(8'h01); send_short(8'h23);
      send_short(8'h45);
      repeat (3) @(posedge sys_clk);
      #3 sys_rst_n = 1'b0;
      model_reset();
      #1 check("rst_issue_valid", 32'(cmd_valid), 32'h0);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      cmd_ready = 1'b1;

      // Randomized frames
      for (int f = 0; f < 60; f++) begin
         r = $urandom_range(0, 9);
         op = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
         if (r == 0) begin
            do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
            h = $urandom_range(2, 13);
            send_byte(b, h, $urandom_range(1, T - h));
         end else if (r == 1) begin
            k = (op == 8'h57) ? $urandom_range(0, 4) : $urandom_range(0, 2);
            for (int i = 0; i <= k; i++) begin
               b = (i == 0) ? op : 8'($urandom);
               h = $urandom_range(2, 13);
               if (i == k) l = T - h + $urandom_range(1, 4);
               else l = $urandom_range(1, T - h);
               send_byte(b, h, l);
            end
         end else begin
            k = (op == 8'h57) ? 6 : 4;
            for (int i = 0; i < k; i++) begin
               b = (i == 0) ? op : 8'($urandom);
               h = $urandom_range(2, 13);
               send_byte(b, h, $urandom_range(1, T - h));
            end
         end
      end

      repeat (T + 10) @(posedge sys_clk);
      #1;
      check("cmd_q_empty", 32'(cmd_q.size()), 32'h0);
      check("err_q_empty", 32'(err_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
